// File: rtl/piso_shift_tx.sv
// ============================================================================
//  Module   : piso_shift_tx
//  Purpose  : Parallel-in, serial-out transmitter with valid/ready word intake,
//             strobe-paced bit output, last-bit flag and synchronous abort.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module piso_shift_tx #(
  parameter int N     = 16,
  parameter bit RIGHT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         shift,
  input  logic         clear,
  output logic         out,
  output logic         out_valid,
  output logic         last,
  output logic         busy
);

  localparam int           CW       = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          out_valid_q, out_valid_d;

  logic          last_bit;
  logic          load_word;
  logic [N-1:0]  shreg_adv;

  assign last_bit  = out_valid_q & (cnt_q == LAST_CNT);

  // in_ready is the only output with a combinational path from inputs.
  assign in_ready  = ~reset & ~clear &
                     ((state_q == ST_IDLE) | ((state_q == ST_SEND) & last_bit & shift));
  assign load_word = in_valid & in_ready;

  assign shreg_adv = RIGHT ? {1'b0, shreg_q[N-1:1]} : {shreg_q[N-2:0], 1'b0};

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      state_d     = ST_IDLE;
      shreg_d     = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else if (load_word) begin
      state_d     = ST_SEND;
      shreg_d     = in_data;
      cnt_d       = '0;
      out_valid_d = 1'b1;
    end else if ((state_q == ST_SEND) && shift) begin
      if (last_bit) begin
        state_d     = ST_IDLE;
        shreg_d     = '0;
        cnt_d       = '0;
        out_valid_d = 1'b0;
      end else begin
        shreg_d = shreg_adv;
        cnt_d   = cnt_q + CW'(1);
      end
    end

    // The serial line always mirrors the emitting end of the next shift register.
    out_d = out_valid_d & (RIGHT ? shreg_d[0] : shreg_d[N-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign last      = last_bit;
  assign busy      = (state_q == ST_SEND);

endmodule

`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
// ============================================================================
//  Module   : tb_piso_shift_tx
//  Purpose  : Directed self-checking bench for piso_shift_tx (LSB- and MSB-first).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_piso_shift_tx;

  logic        clk;
  logic        reset;
  logic [15:0] d0, d1;
  logic        iv0, iv1, sh0, sh1, clr0, clr1;
  logic        rdy0, rdy1, out0, out1, ov0, ov1, last0, last1, busy0, busy1;

  int checks;
  int errors;

  piso_shift_tx #(.N(16), .RIGHT(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .in_data(d0), .in_valid(iv0), .in_ready(rdy0),
    .shift(sh0), .clear(clr0), .out(out0), .out_valid(ov0), .last(last0), .busy(busy0)
  );

  piso_shift_tx #(.N(16), .RIGHT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_data(d1), .in_valid(iv1), .in_ready(rdy1),
    .shift(sh1), .clear(clr1), .out(out1), .out_valid(ov1), .last(last1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:15] e1;
    logic [0:15] e6;
    logic [15:0] rx;
    logic [15:0] w3;
    int          n;
    int          cyc;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    d0 = '0; d1 = '0;
    iv0 = 0; iv1 = 0; sh0 = 0; sh1 = 0; clr0 = 0; clr1 = 0;

    // Reset state
    #2;
    chk("rst_ready", rdy0, 0);
    chk("rst_out", out0, 0);
    chk("rst_valid", ov0, 0);
    chk("rst_last", last0, 0);
    chk("rst_busy", busy0, 0);
    step; step;
    reset = 1'b0;
    #1;
    chk("idle_ready", rdy0, 1);
    chk("idle_busy", busy0, 0);

    // 1: A5C3 LSB-first, shift held high
    e1 = 16'b1100_0011_1010_0101;
    d0 = 16'hA5C3; iv0 = 1; sh0 = 1;
    step;
    iv0 = 0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t1_out%0d", k), out0, e1[k]);
      chk($sformatf("t1_ov%0d", k), ov0, 1);
      chk($sformatf("t1_last%0d", k), last0, (k == 15));
      step;
    end
    chk("t1_end_ov", ov0, 0);
    chk("t1_end_busy", busy0, 0);
    chk("t1_end_ready", rdy0, 1);

    // 2: loopback reassembly, LSB-first 8001
    d0 = 16'h8001; iv0 = 1;
    step;
    iv0 = 0;
    rx = '0;
    for (int k = 0; k < 16; k++) begin
      rx = {out0, rx[15:1]};
      step;
    end
    chk("t2_lsb_word", rx, 16'h8001);
    chk("t2_lsb_ov", ov0, 0);

    // 2b: loopback reassembly, MSB-first 1234
    d1 = 16'h1234; iv1 = 1; sh1 = 1;
    step;
    iv1 = 0;
    rx = '0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) chk("t2_msb_first", out1, 0);
      if (k == 3) chk("t2_msb_bit3", out1, 1);
      rx = {rx[14:0], out1};
      step;
    end
    chk("t2_msb_word", rx, 16'h1234);
    chk("t2_msb_ov", ov1, 0);
    sh1 = 0;

    // 3: stalled shifting, one strobe every third cycle
    w3 = 16'h00F1;
    sh0 = 0;
    d0 = w3; iv0 = 1;
    step;
    iv0 = 0;
    n = 0; cyc = 0; rx = '0;
    while (n < 16 && cyc < 100) begin
      sh0 = (cyc % 3 == 0);
      chk($sformatf("t3_out_c%0d", cyc), out0, w3[n]);
      chk($sformatf("t3_ov_c%0d", cyc), ov0, 1);
      if (sh0) begin
        rx = {out0, rx[15:1]};
        n++;
      end
      step;
      cyc++;
    end
    chk("t3_strobes", n, 16);
    chk("t3_cycles", cyc, 46);
    chk("t3_word", rx, w3);
    chk("t3_end_ov", ov0, 0);
    sh0 = 1;

    // 4: back-to-back FFFF then 0000
    d0 = 16'hFFFF; iv0 = 1;
    step;
    d0 = 16'h0000;
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("t4_ov%0d", k), ov0, 1);
      chk($sformatf("t4_out%0d", k), out0, (k < 16));
      chk($sformatf("t4_last%0d", k), last0, (k == 15 || k == 31));
      if (k == 3)  chk("t4_ready_mid", rdy0, 0);
      if (k == 15) chk("t4_ready_last", rdy0, 1);
      if (k == 16) iv0 = 0;
      step;
    end
    chk("t4_end_ov", ov0, 0);
    chk("t4_end_busy", busy0, 0);

    // 5: clear at bit 5 with a competing word
    d0 = 16'hFFFF; iv0 = 1;
    step;
    iv0 = 0;
    for (int k = 0; k < 5; k++) step;
    chk("t5_bit5_last", last0, 0);
    clr0 = 1; iv0 = 1; d0 = 16'h1235;
    #1;
    chk("t5_clear_ready", rdy0, 0);
    step;
    chk("t5_clr_ov", ov0, 0);
    chk("t5_clr_busy", busy0, 0);
    chk("t5_clr_out", out0, 0);
    clr0 = 0;
    #1;
    chk("t5_ready_after", rdy0, 1);
    step;
    iv0 = 0;
    chk("t5_acc_busy", busy0, 1);
    chk("t5_acc_out0", out0, 1);
    step;
    chk("t5_acc_out1", out0, 0);
    clr0 = 1;
    step;
    clr0 = 0;
    chk("t5_abort_ov", ov0, 0);

    // 6: asynchronous reset at bit 9
    d0 = 16'hFFFF; iv0 = 1;
    step;
    iv0 = 0;
    for (int k = 0; k < 9; k++) step;
    chk("t6_pre_out", out0, 1);
    chk("t6_pre_ov", ov0, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_rst_out", out0, 0);
    chk("t6_rst_ov", ov0, 0);
    chk("t6_rst_last", last0, 0);
    chk("t6_rst_busy", busy0, 0);
    chk("t6_rst_ready", rdy0, 0);
    step;
    chk("t6_rst_hold_ov", ov0, 0);
    reset = 1'b0;
    #1;
    chk("t6_rel_ready", rdy0, 1);
    e6 = 16'b1111_0000_1111_0000;
    d0 = 16'h0F0F; iv0 = 1;
    step;
    iv0 = 0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t6_out%0d", k), out0, e6[k]);
      chk($sformatf("t6_last%0d", k), last0, (k == 15));
      step;
    end
    chk("t6_end_ov", ov0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
